icache_ro: RTL

//  Read-only direct-mapped instruction cache; the responder on the ICACHE_* word interface driven by the fetch

---
 rtl/icache_ro_pkg.sv | 15 +
 rtl/icache_tag_array.sv | 45 ++++
 rtl/icache_ro.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/icache_ro_pkg.sv
// Shared definitions for the read-only instruction cache.
// Optional statistics are enabled by defining ICACHE_STATS_EN.
package icache_ro_pkg;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_t;

    localparam int WORD_W = 32;
    localparam int WORDS  = 4;
    localparam int LINE_W = WORD_W * WORDS;
    localparam int MEM_AW = 28;

endpackage

// File: rtl/icache_tag_array.sv
// Valid, tag and line storage: one write port, combinational read by index.
// Valid bits clear on reset; a write coinciding with reset is dropped.
module icache_tag_array
    import icache_ro_pkg::*;
#(
    parameter int BLOCK_NUM = 8,
    parameter int IDX_W     = $clog2(BLOCK_NUM),
    parameter int TAG_W     = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [TAG_W-1:0]  wtag_i,
    input  logic [LINE_W-1:0] wline_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic              rvalid_o,
    output logic [TAG_W-1:0]  rtag_o,
    output logic [LINE_W-1:0] rline_o
);

    logic [BLOCK_NUM-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [BLOCK_NUM];
    logic [LINE_W-1:0]    line_q [BLOCK_NUM];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i && !rst) begin
            tag_q[widx_i]  <= wtag_i;
            line_q[widx_i] <= wline_i;
        end
    end

    assign rvalid_o = valid_q[ridx_i];
    assign rtag_o   = tag_q[ridx_i];
    assign rline_o  = line_q[ridx_i];

endmodule

// File: rtl/icache_ro.sv
// Read-only direct-mapped instruction cache with whole-line refill.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt counters.
module icache_ro
    import icache_ro_pkg::*;
#(
    parameter int BLOCK_NUM = 8,
    parameter int ADDR_W    = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic [31:0]       proc_rdata,
    output logic              proc_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
`ifdef ICACHE_STATS_EN
    input  logic              mem_ready,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`else
    input  logic              mem_ready
`endif
);

    localparam int IDX_W = $clog2(BLOCK_NUM);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    state_t            state_q, state_d;
    logic [ADDR_W-3:0] maddr_q, maddr_d;
    logic              mreq_q, mreq_d;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [1:0]        woff;
    logic              rvalid;
    logic [TAG_W-1:0]  rtag;
    logic [LINE_W-1:0] rline;
    logic              hit;
    logic              we;

    assign idx  = proc_addr[IDX_W+1:2];
    assign tag  = proc_addr[ADDR_W-1:IDX_W+2];
    assign woff = proc_addr[1:0];

    icache_tag_array #(
        .BLOCK_NUM (BLOCK_NUM),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we),
        .widx_i   (maddr_q[IDX_W-1:0]),
        .wtag_i   (maddr_q[ADDR_W-3:IDX_W]),
        .wline_i  (mem_rdata),
        .ridx_i   (idx),
        .rvalid_o (rvalid),
        .rtag_o   (rtag),
        .rline_o  (rline)
    );

    assign hit        = proc_read && rvalid && (rtag == tag);
    assign proc_rdata = rline[{woff, 5'd0} +: WORD_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            maddr_q <= '0;
            mreq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            maddr_q <= maddr_d;
            mreq_q  <= mreq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        maddr_d = maddr_q;
        mreq_d  = mreq_q;
        unique case (state_q)
            S_IDLE: begin
                if (proc_read && !hit) begin
                    state_d = S_REFILL;
                    maddr_d = proc_addr[ADDR_W-1:2];
                    mreq_d  = 1'b1;
                end
            end
            S_REFILL: begin
                // The latched line always completes, whatever proc_addr does meanwhile.
                if (mem_ready) begin
                    state_d = S_IDLE;
                    mreq_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                mreq_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        proc_stall = 1'b0;
        we         = 1'b0;
        unique case (state_q)
            S_IDLE:   proc_stall = proc_read && !hit;
            S_REFILL: begin
                proc_stall = 1'b1;
                we         = mem_ready;
            end
            default:  proc_stall = 1'b0;
        endcase
    end

    assign mem_read  = mreq_q;
    assign mem_addr  = maddr_q;
    assign mem_write = 1'b0;
    assign mem_wdata = '0;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == S_IDLE && hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (state_q == S_IDLE && state_d == S_REFILL) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    // Write-side inputs have no effect on a read-only cache.
    logic unused_ok;
    assign unused_ok = ^{proc_write, proc_wdata};

endmodule
